// File: rtl/common.sv
// Shared pipeline types for the memory stage: decoded ops, bus request/response, stage records.
package common;

  localparam int unsigned XLEN = 64;

  typedef enum logic [3:0] {
    OpAlu, OpLb, OpLh, OpLw, OpLd, OpLbu, OpLhu, OpLwu, OpSb, OpSh, OpSw, OpSd
  } decoded_op_t;

  typedef enum logic [2:0] {
    MSize1 = 3'd0,
    MSize2 = 3'd1,
    MSize4 = 3'd2,
    MSize8 = 3'd3
  } msize_t;

  typedef logic [1:0] mem_state_t;
  localparam mem_state_t StIdle = 2'd0;
  localparam mem_state_t StWait = 2'd1;
  localparam mem_state_t StDone = 2'd2;

  typedef struct packed {
    decoded_op_t op;
    logic        regwrite;
  } control_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] result;
    logic [4:0]      dst;
    control_t        ctl;
    logic            csr_we;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_data;
    logic [XLEN-1:0] mem_addr;
    logic            stall;
  } execute_data_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] result;
    logic [4:0]      dst;
    control_t        ctl;
    logic            csr_we;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_data;
    logic            misalign;
    logic            valid;
  } memory_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  function automatic logic [3:0] mem_bytes(decoded_op_t op);
    case (op)
      OpLb, OpLbu, OpSb: return 4'd1;
      OpLh, OpLhu, OpSh: return 4'd2;
      OpLw, OpLwu, OpSw: return 4'd4;
      OpLd, OpSd:        return 4'd8;
      default:           return 4'd0;
    endcase
  endfunction

  function automatic msize_t mem_size(decoded_op_t op);
    case (op)
      OpLh, OpLhu, OpSh: return MSize2;
      OpLw, OpLwu, OpSw: return MSize4;
      OpLd, OpSd:        return MSize8;
      default:           return MSize1;
    endcase
  endfunction

  function automatic logic is_load(decoded_op_t op);
    return op inside {OpLb, OpLh, OpLw, OpLd, OpLbu, OpLhu, OpLwu};
  endfunction

  function automatic logic is_store(decoded_op_t op);
    return op inside {OpSb, OpSh, OpSw, OpSd};
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store strobe/data placement and load extraction with sign/zero extension.
module mem_align
  import common::*;
(
  input  decoded_op_t op,
  input  logic [2:0]  offset,
  input  logic [63:0] storeData,
  input  logic [63:0] loadData,
  output logic [7:0]  strobe,
  output logic [63:0] wdata,
  output logic [63:0] ldResult
);

  logic [15:0] mask;
  logic [15:0] strobeWide;
  logic [63:0] shifted;

  always_comb begin
    mask       = (16'd1 << mem_bytes(op)) - 16'd1;
    // Misaligned wide accesses spill past lane 7; those bits are simply dropped.
    strobeWide = mask << offset;
    strobe     = is_store(op) ? strobeWide[7:0] : 8'h00;
    wdata      = storeData << {offset, 3'b000};
    shifted    = loadData >> {offset, 3'b000};
    case (op)
      OpLb:    ldResult = {{56{shifted[7]}}, shifted[7:0]};
      OpLh:    ldResult = {{48{shifted[15]}}, shifted[15:0]};
      OpLw:    ldResult = {{32{shifted[31]}}, shifted[31:0]};
      OpLbu:   ldResult = {56'd0, shifted[7:0]};
      OpLhu:   ldResult = {48'd0, shifted[15:0]};
      OpLwu:   ldResult = {32'd0, shifted[31:0]};
      default: ldResult = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory stage: one data-bus transaction per load/store, held stable until data_ok.
// Optional build macro MEM_MISALIGN_TRAP_EN turns misaligned H/W/D accesses into a trap.
module mem_access
  import common::*;
(
  input  logic          clk,
  input  logic          reset,
  input  execute_data_t dataE,
  input  logic          stall_in,
  input  logic          flush,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output memory_data_t  dataM,
  output logic          stallM
);

  mem_state_t  state, stateNext;
  dbus_req_t   req_q, reqNew;
  decoded_op_t opQ;
  logic [63:0] ld_q;
  logic        kill_q, killNext;
  logic        isMem, misaligned, issue, ldLatch;
  decoded_op_t alignOp;
  logic [2:0]  alignOff;
  logic [7:0]  strobe;
  logic [63:0] wdata, ldResult, completed;

  assign isMem = !dataE.stall && (is_load(dataE.ctl.op) || is_store(dataE.ctl.op));

`ifdef MEM_MISALIGN_TRAP_EN
  logic [3:0] opBytes;
  assign opBytes    = mem_bytes(dataE.ctl.op);
  assign misaligned = isMem && ((dataE.mem_addr[2:0] & 3'(opBytes - 4'd1)) != 3'd0);
`else
  assign misaligned = 1'b0;
`endif

  assign issue = (state == StIdle) && isMem && !flush && !misaligned;

  // Outstanding transactions extract against the latched request, not the live dataE.
  assign alignOp  = (state == StIdle) ? dataE.ctl.op : opQ;
  assign alignOff = (state == StIdle) ? dataE.mem_addr[2:0] : req_q.addr[2:0];

  mem_align u_align (
    .op       (alignOp),
    .offset   (alignOff),
    .storeData(dataE.result),
    .loadData (dresp.data),
    .strobe   (strobe),
    .wdata    (wdata),
    .ldResult (ldResult)
  );

  assign completed = is_load(alignOp) ? ldResult : dataE.result;

  always_comb begin
    reqNew        = '0;
    reqNew.valid  = 1'b1;
    reqNew.addr   = dataE.mem_addr;
    reqNew.size   = mem_size(dataE.ctl.op);
    reqNew.strobe = strobe;
    reqNew.data   = wdata;
  end

  always_comb begin
    stateNext      = state;
    killNext       = kill_q;
    ldLatch        = 1'b0;
    dreq           = '0;
    stallM         = 1'b0;
    dataM          = '0;
    dataM.pc       = dataE.pc;
    dataM.result   = dataE.result;
    dataM.dst      = dataE.dst;
    dataM.ctl      = dataE.ctl;
    dataM.csr_we   = dataE.csr_we;
    dataM.csr_addr = dataE.csr_addr;
    dataM.csr_data = dataE.csr_data;
    dataM.valid    = !dataE.stall;

    case (state)
      StIdle: begin
        if (issue) begin
          dreq = reqNew;
          if (dresp.data_ok) begin
            dataM.result = completed;
            if (stall_in) begin
              ldLatch   = 1'b1;
              stateNext = StDone;
            end
          end else begin
            stallM      = 1'b1;
            dataM.valid = 1'b0;
            stateNext   = StWait;
          end
        end else if (misaligned) begin
          dataM.misalign     = 1'b1;
          dataM.ctl.regwrite = 1'b0;
        end
        if (flush) begin
          dataM.valid        = 1'b0;
          dataM.ctl.regwrite = 1'b0;
        end
      end
      StWait: begin
        dreq        = req_q;
        stallM      = 1'b1;
        dataM.valid = 1'b0;
        if (flush) killNext = 1'b1;
        if (dresp.data_ok) begin
          stallM = 1'b0;
          if (kill_q || flush) begin
            dataM.ctl.regwrite = 1'b0;
            killNext           = 1'b0;
            stateNext          = StIdle;
          end else begin
            dataM.valid  = 1'b1;
            dataM.result = completed;
            ldLatch      = 1'b1;
            stateNext    = stall_in ? StDone : StIdle;
          end
        end
      end
      StDone: begin
        dataM.result = ld_q;
        if (flush) begin
          dataM.valid        = 1'b0;
          dataM.ctl.regwrite = 1'b0;
          stateNext          = StIdle;
        end else if (!stall_in) begin
          stateNext = StIdle;
        end
      end
      default: stateNext = StIdle;
    endcase

    // Async reset must drop the bus request immediately, even mid-transaction.
    if (reset) begin
      dreq        = '0;
      stallM      = 1'b0;
      dataM.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= StIdle;
      req_q  <= '0;
      opQ    <= OpAlu;
      ld_q   <= '0;
      kill_q <= 1'b0;
    end else begin
      state  <= stateNext;
      kill_q <= killNext;
      if (issue) begin
        req_q <= reqNew;
        opQ   <= dataE.ctl.op;
      end
      if (ldLatch) ld_q <= completed;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: scoreboard of retired results plus per-transaction bus checks.
module tb_mem_access;
  import common::*;

  logic          clk;
  logic          reset;
  execute_data_t dataE;
  logic          stall_in;
  logic          flush;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;
  memory_data_t  dataM;
  logic          stallM;

  mem_access dut (
    .clk     (clk),
    .reset   (reset),
    .dataE   (dataE),
    .stall_in(stall_in),
    .flush   (flush),
    .dreq    (dreq),
    .dresp   (dresp),
    .dataM   (dataM),
    .stallM  (stallM)
  );

  typedef struct packed {
    logic [63:0] result;
    logic        regwrite;
    logic        misalign;
  } exp_t;

  exp_t exp_q[$];
  exp_t monE;
  int   nCmp = 0;
  int   nBad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    nCmp++;
    if (act !== req) begin
      nBad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic execute_data_t mk(decoded_op_t op, logic [63:0] addr, logic [63:0] rs2,
                                       logic rw);
    execute_data_t d;
    d              = '0;
    d.pc           = 64'h8000_0100;
    d.result       = rs2;
    d.dst          = 5'd10;
    d.ctl.op       = op;
    d.ctl.regwrite = rw;
    d.mem_addr     = addr;
    d.stall        = 1'b0;
    return d;
  endfunction

  function automatic execute_data_t bubble();
    execute_data_t d;
    d       = '0;
    d.stall = 1'b1;
    return d;
  endfunction

  // Monitor: a result retires when dataM is valid and the stage is not held.
  always @(negedge clk) begin
    if (!reset && dataM.valid && !stall_in) begin
      if (exp_q.size() == 0) begin
        nCmp++;
        nBad++;
        $display("FAIL sb_unexpected: got retire with result %h, required none", dataM.result);
      end else begin
        monE = exp_q.pop_front();
        check64("sb_result", dataM.result, monE.result);
        check64("sb_regwrite", 64'(dataM.ctl.regwrite), 64'(monE.regwrite));
        check64("sb_misalign", 64'(dataM.misalign), 64'(monE.misalign));
      end
    end
  end

  // lat = cycles without data_ok; hold = cycles stall_in stays high starting at data_ok.
  task automatic do_op(input decoded_op_t op, input logic [63:0] addr, input logic [63:0] rs2,
                       input logic rw, input int lat, input int hold, input logic [63:0] rdata,
                       input msize_t expSize, input logic [7:0] expStrobe,
                       input logic [63:0] expWdata, input logic [63:0] expResult);
    dbus_req_t first;
    int        stallCnt;
    int        validCnt;
    stallCnt = 0;
    validCnt = 0;
    first    = '0;
    exp_q.push_back('{result: expResult, regwrite: rw, misalign: 1'b0});
    dataE = mk(op, addr, rs2, rw);
    for (int c = 0; c <= lat; c++) begin
      dresp.data_ok = (c == lat);
      dresp.data    = (c == lat) ? rdata : 64'h0;
      stall_in      = (c == lat) && (hold > 0);
      @(negedge clk);
      if (dreq.valid) validCnt++;
      if (stallM) stallCnt++;
      if (c == 0) begin
        first = dreq;
      end else begin
        check64("dreq_addr_stable", dreq.addr, first.addr);
        check64("dreq_data_stable", dreq.data, first.data);
        check64("dreq_ctl_stable", 64'({dreq.valid, dreq.size, dreq.strobe}),
                64'({first.valid, first.size, first.strobe}));
      end
      @(posedge clk); #1;
    end
    dresp.data_ok = 1'b0;
    dresp.data    = 64'h0;
    for (int h = 1; h < hold; h++) begin
      stall_in = 1'b1;
      @(negedge clk);
      if (dreq.valid) validCnt++;
      @(posedge clk); #1;
    end
    if (hold > 0) begin
      stall_in = 1'b0;
      @(negedge clk);
      if (dreq.valid) validCnt++;
      @(posedge clk); #1;
    end
    check64("req_valid", 64'(first.valid), 64'd1);
    check64("req_addr", first.addr, addr);
    check64("req_size", 64'(first.size), 64'(expSize));
    check64("req_strobe", 64'(first.strobe), 64'(expStrobe));
    check64("req_data", first.data, expWdata);
    check64("stallM_cycles", 64'(stallCnt), 64'(lat));
    check64("dreq_valid_cycles", 64'(validCnt), 64'(lat + 1));
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    stall_in      = 1'b0;
    dresp         = '0;
    dresp.data_ok = 1'b1;
    dataE         = mk(OpLd, 64'h8000_1000, 64'h0, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check64("reset_dreq_valid", 64'(dreq.valid), 64'd0);
    check64("reset_dreq_addr", dreq.addr, 64'h0);
    check64("reset_stallM", 64'(stallM), 64'd0);
    check64("reset_dataM_valid", 64'(dataM.valid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    dresp = '0;
    dataE = bubble();
    @(posedge clk); #1;

    // LD with 3 wait cycles
    do_op(OpLd, 64'h8000_1000, 64'h0, 1'b1, 3, 0, 64'h1122_3344_5566_7788,
          MSize8, 8'h00, 64'h0, 64'h1122_3344_5566_7788);
    // LB / LBU top lane
    do_op(OpLb, 64'h8000_1007, 64'h0, 1'b1, 0, 0, 64'h8000_0000_0000_0000,
          MSize1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
    do_op(OpLbu, 64'h8000_1007, 64'h0, 1'b1, 1, 0, 64'h8000_0000_0000_0000,
          MSize1, 8'h00, 64'h0, 64'h0000_0000_0000_0080);
    // Stores
    do_op(OpSh, 64'h8000_1002, 64'hABCD, 1'b0, 1, 0, 64'h0,
          MSize2, 8'h0C, 64'h0000_0000_ABCD_0000, 64'hABCD);
    do_op(OpSd, 64'h8000_1008, 64'h0102_0304_0506_0708, 1'b0, 0, 0, 64'h0,
          MSize8, 8'hFF, 64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708);
    do_op(OpSb, 64'h8000_1005, 64'h1FF, 1'b0, 0, 0, 64'h0,
          MSize1, 8'h20, 64'h0001_FF00_0000_0000, 64'h1FF);
    // Zero-wait LW held by stall_in for 2 cycles
    do_op(OpLw, 64'h8000_1004, 64'h0, 1'b1, 0, 2, 64'hDEAD_BEEF_CAFE_F00D,
          MSize4, 8'h00, 64'h0, 64'hFFFF_FFFF_DEAD_BEEF);
    do_op(OpLwu, 64'h8000_1000, 64'h0, 1'b1, 2, 1, 64'hDEAD_BEEF_CAFE_F00D,
          MSize4, 8'h00, 64'h0, 64'h0000_0000_CAFE_F00D);
    do_op(OpLh, 64'h8000_1006, 64'h0, 1'b1, 0, 0, 64'h7FFF_0000_0000_0000,
          MSize2, 8'h00, 64'h0, 64'h0000_0000_0000_7FFF);

    // Non-memory op bypasses
    exp_q.push_back('{result: 64'h55, regwrite: 1'b1, misalign: 1'b0});
    dataE = mk(OpAlu, 64'h8000_1000, 64'h55, 1'b1);
    @(negedge clk);
    check64("bypass_dreq_valid", 64'(dreq.valid), 64'd0);
    check64("bypass_stallM", 64'(stallM), 64'd0);
    @(posedge clk); #1;

    // Flush while waiting; data_ok arrives two cycles after the flush
    dataE = mk(OpLd, 64'h8000_1010, 64'h0, 1'b1);
    @(negedge clk);
    check64("fl_issue_stallM", 64'(stallM), 64'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check64("fl_wait_dreq_valid", 64'(dreq.valid), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check64("fl_wait_stallM", 64'(stallM), 64'd1);
    @(posedge clk); #1;
    dresp.data_ok = 1'b1;
    dresp.data    = 64'hFFFF;
    @(negedge clk);
    check64("fl_done_valid", 64'(dataM.valid), 64'd0);
    check64("fl_done_regwrite", 64'(dataM.ctl.regwrite), 64'd0);
    check64("fl_done_stallM", 64'(stallM), 64'd0);
    @(posedge clk); #1;
    dresp = '0;
    do_op(OpLbu, 64'h8000_1011, 64'h0, 1'b1, 0, 0, 64'h0000_0000_0000_A500,
          MSize1, 8'h00, 64'h0, 64'h0000_0000_0000_00A5);

`ifdef MEM_MISALIGN_TRAP_EN
    exp_q.push_back('{result: 64'h0, regwrite: 1'b0, misalign: 1'b1});
    dataE = mk(OpLw, 64'h8000_1002, 64'h0, 1'b1);
    @(negedge clk);
    check64("mis_dreq_valid", 64'(dreq.valid), 64'd0);
    check64("mis_stallM", 64'(stallM), 64'd0);
    check64("mis_flag", 64'(dataM.misalign), 64'd1);
    @(posedge clk); #1;
`else
    do_op(OpLw, 64'h8000_1002, 64'h0, 1'b1, 0, 0, 64'h0000_1234_5678_0000,
          MSize4, 8'h00, 64'h0, 64'h0000_0000_1234_5678);
`endif

    // Async reset in the middle of a wait
    dataE = mk(OpLd, 64'h8000_1018, 64'h0, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check64("rst_pre_dreq_valid", 64'(dreq.valid), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check64("rst_async_dreq_valid", 64'(dreq.valid), 64'd0);
    check64("rst_async_stallM", 64'(stallM), 64'd0);
    dataE = bubble();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check64("rst_idle_stallM", 64'(stallM), 64'd0);
    check64("rst_idle_dreq_valid", 64'(dreq.valid), 64'd0);
    @(posedge clk); #1;
    do_op(OpLd, 64'h8000_1020, 64'h0, 1'b1, 1, 0, 64'h0BAD_F00D_1234_5678,
          MSize8, 8'h00, 64'h0, 64'h0BAD_F00D_1234_5678);

    dataE = bubble();
    @(posedge clk); #1;
    @(negedge clk);
    check64("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory stage of the five-stage pipeline. It consumes the EX/MEM register output (`execute_data_t`), issues at most one data-bus transaction per instruction, and produces `memory_data_t` for the MEM/WB register. A transaction is held stable on the bus until `data_ok`. `stallM` freezes the upstream registers while the transaction is in flight.

## Interface
Parameters:
- none; all widths come from the shared package (XLEN=64, 8-byte bus lanes).

Ports:
- `clk`  in  1  pipeline clock; one clock domain.
- `reset`  in  1  asynchronous, active-high.
- `dataE`  in  `execute_data_t`  EX/MEM register output; `stall`=1 marks a bubble.
- `stall_in`  in  1  hold request from the global hazard unit; the same `dataE` is presented again next cycle.
- `flush`  in  1  squash the current instruction.
- `dreq`  out  `dbus_req_t`  fields: `valid`, `addr[63:0]`, `size` (`msize_t`), `strobe[7:0]`, `data[63:0]`.
- `dresp`  in  `dbus_resp_t`  fields: `addr_ok`, `data_ok`, `data[63:0]`.
- `dataM`  out  `memory_data_t`  to the MEM/WB register: `pc`, `result`, `dst`, `ctl`, `csr_*`, `misalign`, `valid`.
- `stallM`  out  1  memory transaction outstanding; upstream must hold.

## Operation
- Memory ops:
  - loads: LB, LH, LW, LD, LBU, LHU, LWU.
  - stores: SB, SH, SW, SD.
  - Any other op, or a bubble, bypasses the block: `dataM` = `dataE` fields, `valid` = !`dataE.stall`, and no bus activity.
- Request formation:
  - `addr` = `mem_addr`.
  - `size` = 1/2/4/8 bytes per op.
  - lane offset a = `addr[2:0]`.
  - `strobe` = ((1<<bytes)-1)<<a for stores, 0 for loads.
  - `data` = `dataE.result` (store data = rs2) << 8a.
- Load data: extract `dresp.data[8a +: 8*bytes]`. Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU/LD. The extracted value replaces `result`.
- FSM (`state` register):
  - IDLE: a mem op with !flush drives `dreq` combinationally from `dataE` and latches the request into `req_q`.
    - If `data_ok` arrives in the same cycle, go to DONE when `stall_in` is high, otherwise stay in IDLE.
    - Without `data_ok`, go to WAIT.
  - WAIT: `dreq` is driven from `req_q` (stable), `stallM`=1.
    - On `data_ok`, capture the load data into `ld_q`.
    - Then go to DONE if `stall_in` is high, else IDLE.
  - DONE: the completed result is held in `ld_q`; `dreq.valid`=0; no reissue.
    - Leave for IDLE when `stall_in`=0.
    - `dataM` is sourced from `ld_q`.
- `stallM` = WAIT, or (IDLE and a request issued without `data_ok`).
- `addr_ok` is ignored; completion is `data_ok` only.
- Flush:
  - In IDLE or DONE: `dataM.valid`=0, `ctl.regwrite`=0, and the state returns to IDLE.
  - In WAIT: the bus transaction must still complete. A `kill_q` bit is set; on `data_ok` the result is discarded (`valid`=0) and the state returns to IDLE.

## Timing
- Values during `reset`:
  - state IDLE, `req_q`/`ld_q`/`kill_q` = 0.
  - `dreq`='0, `stallM`=0.
  - `dataM.valid`=0.
- Latency:
  - zero-wait bus: 0 extra cycles.
  - N-cycle `data_ok`: `stallM` high for exactly N cycles.
- `dreq` fields change only on a new issue from IDLE.
- A reset during WAIT abandons the transaction: `dreq.valid` drops asynchronously.
- Back-to-back mem ops: the next request issues in the cycle after `data_ok` (IDLE with `stall_in`=0).

## Configuration
- `MEM_MISALIGN_TRAP_EN`
  - Defined:
    - Misaligned H/W/D access (`addr[0]`, `addr[1:0]`, `addr[2:0]` nonzero respectively) issues no request.
    - `dataM.misalign`=1, `regwrite`=0, `stallM`=0.
  - Undefined:
    - No check; `misalign` is tied to 0.
    - The request issues with the raw address; strobe and shifted data are truncated to 8 bits/64 bits.

## Structure
- Shared package `common` additions:
  - `memory_data_t.misalign`.
  - `mem_state_t` enum (IDLE, WAIT, DONE).
  - `msize_t` encodings.
  - a `mem_bytes(op)` function.
- Submodule `mem_align`: combinational strobe/wdata generation plus load extraction and extension. The FSM and registers stay in `mem_access`.

## Test plan
- LD at 0x80001000, `data_ok` after 3 cycles, `dresp.data`=0x1122334455667788 -> `stallM` high 3 cycles, `dreq` stable, `result`=0x1122334455667788.
- LB at 0x80001007, `dresp.data`=0x80_00000000000000 -> `result`=0xFFFFFFFFFFFFFF80; LBU at the same address -> 0x80.
- SH at 0x80001002, rs2=0xABCD -> `strobe`=0x0C, `data`=0x00000000ABCD0000, `size`=2 bytes.
- Zero-wait LW with `stall_in`=1 for 2 cycles -> exactly one `dreq.valid` pulse; `dataM` is held from `ld_q`; state returns to IDLE when `stall_in` falls.
- `flush` in WAIT, `data_ok` 2 cycles later -> transaction completes, `dataM.valid`=0, `regwrite`=0, next op issues normally.
- With `MEM_MISALIGN_TRAP_EN`, LW at 0x80001002 -> no `dreq.valid`, `misalign`=1, `stallM`=0. Async reset asserted mid-WAIT -> `dreq.valid`=0 immediately, state IDLE.
